// File: rtl/ysyx_23060303_imem_responder_if.sv
// ysyx_23060303_imem_responder_if: fetch request/response bus between IFU (master) and instruction memory (slave)
interface ysyx_23060303_imem_responder_if;
  logic req_valid;
  logic req_ready;
  logic [31:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_inst;
  logic rsp_err;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_inst, rsp_err);
  modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_inst, rsp_err);
endinterface

// File: rtl/ysyx_23060303_imem_responder.sv
// ysyx_23060303_imem_responder: handshaked instruction memory returning one word after a fixed latency
module ysyx_23060303_imem_responder #(
  parameter int DEPTH = 1024,
  parameter logic [31:0] BASE = 32'h8000_0000,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  ysyx_23060303_imem_responder_if.slave s,
  input logic wr_en,
  input logic [31:0] wr_addr,
  input logic [31:0] wr_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] req_idx, wr_idx;
  logic req_err, wr_err;
  function automatic logic [31:0] woff(input logic [31:0] a);
    return {2'b0, a[31:2]} - {2'b0, BASE[31:2]};
  endfunction
  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b0) || (a < BASE) || (woff(a) >= 32'(DEPTH));
  endfunction
  assign req_idx = AW'(woff(s.req_addr));
  assign wr_idx = AW'(woff(wr_addr));
  assign req_err = bad(s.req_addr);
  assign wr_err = bad(wr_addr);
  // Array is never reset; writes to unmapped addresses are dropped
  always_ff @(posedge clk)
    if (wr_en && !wr_err) mem[wr_idx] <= wr_data;
  // Read data is snapshotted at accept, so same-edge writes only affect later fetches
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      s.req_ready <= 1'b1;
      s.rsp_valid <= 1'b0;
      s.rsp_inst <= 32'd0;
      s.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (s.req_valid) begin
            s.rsp_inst <= req_err ? 32'd0 : mem[req_idx];
            s.rsp_err <= req_err;
            cnt <= 4'(LATENCY - 1);
            s.req_ready <= 1'b0;
            s.rsp_valid <= LATENCY == 1;
            state <= LATENCY == 1 ? RESP : WAIT;
          end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            s.rsp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RESP:
          if (s.rsp_ready) begin
            s.rsp_valid <= 1'b0;
            s.req_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
